// File: rtl/hash_des_sbox_stream.sv
// Streaming DES-S5 nibble hash: one byte per handshake, UNROLL rounds per clock,
// and a length-keyed final transform that emits a 32-bit digest with a one-cycle pulse.
module hash_des_sbox_stream #(
  parameter int ROUNDS = 4,
  parameter int UNROLL = 1,
  parameter int LEN_W  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  msg_byte,
  input  logic        msg_last,
  output logic [31:0] digest_out,
  output logic        hash_ready,
  output logic        busy,
  output logic        len_overflow
);

  localparam int R    = (UNROLL > 0) ? ROUNDS / UNROLL : 1;
  localparam int RC_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(R - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [31:0]      H_INIT  = 32'h4B71_DF03;

  // DES S5 rows; column 0 sits in the most significant nibble.
  localparam logic [63:0] S5_ROW0 = 64'h2C41_7AB6_853F_D0E9;
  localparam logic [63:0] S5_ROW1 = 64'hEB2C_47D1_50FA_3986;
  localparam logic [63:0] S5_ROW2 = 64'h421B_AD78_F9C5_630E;
  localparam logic [63:0] S5_ROW3 = 64'hB8C7_1E2D_6F09_A453;

  generate
    if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0 || LEN_W < 1 || LEN_W > 64) begin : g_bad_param
      $error("hash_des_sbox_stream: illegal ROUNDS/UNROLL/LEN_W combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_h;
  logic [3:0]        r_s;
  logic              r_last;
  logic [RC_W-1:0]   r_rcnt;
  logic [LEN_W-1:0]  r_len;
  logic [31:0]       r_digest;
  logic              r_hash_ready;
  logic              r_ovf;

  logic [31:0]       w_h_next;
  logic [31:0]       w_digest;
  logic [63:0]       w_c64;

  function automatic logic [3:0] rotl4(input logic [3:0] v, input int r);
    logic [7:0] d;
    d = {v, v} << r;
    return d[7:4];
  endfunction

  function automatic logic [3:0] sbox(input logic [5:0] x);
    logic [63:0] row;
    logic [5:0]  sh;
    case ({x[5], x[0]})
      2'd0:    row = S5_ROW0;
      2'd1:    row = S5_ROW1;
      2'd2:    row = S5_ROW2;
      default: row = S5_ROW3;
    endcase
    sh = {~x[4:1], 2'b00};
    return row[sh +: 4];
  endfunction

  function automatic logic [5:0] m6(input logic [7:0] b);
    return {b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]};
  endfunction

  function automatic logic [5:0] c6(input logic [7:0] c);
    return {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
  endfunction

  // Nibble i lives at [31-4i -: 4]; every output nibble reads its right-hand neighbour.
  function automatic logic [31:0] round_f(input logic [31:0] h, input logic [3:0] s);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[31-4*i -: 4] = rotl4(h[31-4*((i+1)%8) -: 4] ^ s, i / 2);
    end
    return o;
  endfunction

  always_comb begin
    w_h_next = r_h;
    for (int k = 0; k < UNROLL; k++) begin
      w_h_next = round_f(w_h_next, r_s);
    end
  end

  always_comb begin
    w_c64    = 64'(r_len);
    w_digest = '0;
    for (int i = 0; i < 8; i++) begin
      w_digest[31-4*i -: 4] = rotl4(r_h[31-4*((i+1)%8) -: 4] ^ sbox(c6(w_c64[63-8*i -: 8])), i / 2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_h          <= H_INIT;
      r_s          <= '0;
      r_last       <= 1'b0;
      r_rcnt       <= '0;
      r_len        <= '0;
      r_digest     <= '0;
      r_hash_ready <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_hash_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (msg_valid) begin
            r_s     <= sbox(m6(msg_byte));
            r_last  <= msg_last;
            r_rcnt  <= '0;
            r_state <= S_ROUND;
            // Saturate rather than wrap; a zero count marks the first byte of a message.
            if (r_len == LEN_MAX) begin
              r_ovf <= 1'b1;
            end else begin
              r_len <= r_len + LEN_W'(1);
              if (r_len == '0) r_ovf <= 1'b0;
            end
          end
        end
        S_ROUND: begin
          r_h <= w_h_next;
          if (r_rcnt == RC_LAST) begin
            r_state <= r_last ? S_FINAL : S_IDLE;
          end else begin
            r_rcnt <= r_rcnt + RC_W'(1);
          end
        end
        S_FINAL: begin
          r_digest     <= w_digest;
          r_hash_ready <= 1'b1;
          r_h          <= H_INIT;
          r_len        <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign msg_ready    = (r_state == S_IDLE);
  assign busy         = (r_state == S_ROUND) || (r_state == S_FINAL);
  assign digest_out   = r_digest;
  assign hash_ready   = r_hash_ready;
  assign len_overflow = r_ovf;

endmodule

// File: tb/tb_hash_des_sbox_stream.sv
// Directed bench for hash_des_sbox_stream: four instances (default, UNROLL=2, UNROLL=4,
// LEN_W=4) sharing clock, reset and data, each with its own valid.
module tb_hash_des_sbox_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [7:0]  byte_in;
  logic        last_in;
  logic [3:0]  rdy, bsy, hrdy, ovf;
  logic [31:0] dig [4];

  int total = 0;
  int bad   = 0;
  logic [7:0] msg_buf [32];
  int s5 [4][16] = '{
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
    '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
    '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
    '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3}
  };

  always #5 clk = ~clk;

  hash_des_sbox_stream u0 (
    .clk(clk), .rst_n(rst_n), .msg_valid(valid[0]), .msg_ready(rdy[0]), .msg_byte(byte_in),
    .msg_last(last_in), .digest_out(dig[0]), .hash_ready(hrdy[0]), .busy(bsy[0]), .len_overflow(ovf[0]));
  hash_des_sbox_stream #(.UNROLL(2)) u1 (
    .clk(clk), .rst_n(rst_n), .msg_valid(valid[1]), .msg_ready(rdy[1]), .msg_byte(byte_in),
    .msg_last(last_in), .digest_out(dig[1]), .hash_ready(hrdy[1]), .busy(bsy[1]), .len_overflow(ovf[1]));
  hash_des_sbox_stream #(.UNROLL(4)) u2 (
    .clk(clk), .rst_n(rst_n), .msg_valid(valid[2]), .msg_ready(rdy[2]), .msg_byte(byte_in),
    .msg_last(last_in), .digest_out(dig[2]), .hash_ready(hrdy[2]), .busy(bsy[2]), .len_overflow(ovf[2]));
  hash_des_sbox_stream #(.LEN_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .msg_valid(valid[3]), .msg_ready(rdy[3]), .msg_byte(byte_in),
    .msg_last(last_in), .digest_out(dig[3]), .hash_ready(hrdy[3]), .busy(bsy[3]), .len_overflow(ovf[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rl(input logic [3:0] v, input int r);
    logic [7:0] w;
    w = {4'b0, v};
    w = (w << r) | (w >> (4 - r));
    return w[3:0];
  endfunction

  function automatic logic [3:0] sb(input logic [5:0] x);
    return 4'(s5[{x[5], x[0]}][x[4:1]]);
  endfunction

  // Reference hash of msg_buf[0..n-1] with 4 rounds per byte and a len_w-bit saturating count.
  function automatic logic [31:0] model(input int n, input int len_w);
    logic [3:0]  h [8];
    logic [3:0]  t [8];
    logic [7:0]  b;
    logic [7:0]  c;
    logic [5:0]  x;
    logic [3:0]  s;
    logic [63:0] len;
    logic [63:0] lim;
    logic [31:0] d;
    h = '{4'h4, 4'hB, 4'h7, 4'h1, 4'hD, 4'hF, 4'h0, 4'h3};
    for (int j = 0; j < n; j++) begin
      b = msg_buf[j];
      x = {b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]};
      s = sb(x);
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < 8; i++) t[i] = rl(h[(i + 1) % 8] ^ s, i / 2);
        h = t;
      end
    end
    len = 64'(n);
    lim = (len_w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << len_w) - 64'd1);
    if (len > lim) len = lim;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      c = 8'(len >> (56 - 8 * i));
      x = {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
      d[31 - 4 * i -: 4] = rl(h[(i + 1) % 8] ^ sb(x), i / 2);
    end
    return d;
  endfunction

  // Called at a negedge; returns at the negedge right after the transfer edge.
  task automatic send(input int k, input logic [7:0] b, input logic l, input logic junk);
    int waited;
    valid[k] = 1'b1;
    waited = 0;
    while (!rdy[k] && waited < 50) begin
      if (junk) begin
        byte_in = 8'($urandom_range(0, 255));
        last_in = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      waited++;
    end
    check("send_ready_seen", {31'd0, rdy[k]}, 32'd1);
    byte_in = b;
    last_in = l;
    @(posedge clk);
    @(negedge clk);
    if (!junk || l) valid[k] = 1'b0;
    byte_in = 8'($urandom_range(0, 255));
    last_in = junk ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic wait_digest(input int k, input int exp_lat, input logic [31:0] exp_dig, input string tag);
    int cnt;
    cnt = 0;
    while (!hrdy[k] && cnt < 40) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    check({tag, "_pulse"}, {31'd0, hrdy[k]}, 32'd1);
    check({tag, "_latency"}, cnt, exp_lat);
    check({tag, "_digest"}, dig[k], exp_dig);
    check({tag, "_ready_with_pulse"}, {31'd0, rdy[k]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse_drop"}, {31'd0, hrdy[k]}, 32'd0);
    check({tag, "_digest_held"}, dig[k], exp_dig);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    valid   = '0;
    byte_in = '0;
    last_in = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("reset_ready", {31'd0, rdy[k]}, 32'd1);
      check("reset_busy", {31'd0, bsy[k]}, 32'd0);
      check("reset_hash_ready", {31'd0, hrdy[k]}, 32'd0);
      check("reset_digest", dig[k], 32'h0);
      check("reset_ovf", {31'd0, ovf[k]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single zero byte on each unroll variant.
    send(0, 8'h00, 1'b1, 1'b0);
    check("t1_busy_after_transfer", {31'd0, bsy[0]}, 32'd1);
    check("t1_ready_after_transfer", {31'd0, rdy[0]}, 32'd0);
    wait_digest(0, 5, 32'h1440590F, "t1_u1x");
    send(1, 8'h00, 1'b1, 1'b0);
    wait_digest(1, 3, 32'h1440590F, "t3_u2x");
    send(2, 8'h00, 1'b1, 1'b0);
    wait_digest(2, 2, 32'h1440590F, "t3_u4x");

    // Back-to-back messages with valid held: 6-cycle period, idle only on pulse cycles.
    valid[0] = 1'b1;
    byte_in  = 8'h00;
    last_in  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("t2_busy", {31'd0, bsy[0]}, (k % 6 != 0) ? 32'd1 : 32'd0);
      check("t2_ready", {31'd0, rdy[0]}, (k % 6 != 0) ? 32'd0 : 32'd1);
      check("t2_pulse", {31'd0, hrdy[0]}, (k % 6 != 0) ? 32'd0 : 32'd1);
      if (k % 6 == 0) check("t2_digest", dig[0], 32'h1440590F);
    end
    valid[0] = 1'b0;
    @(negedge clk);

    // Multi-byte messages with junk presented while busy.
    msg_buf[0] = 8'hA5; msg_buf[1] = 8'h3C; msg_buf[2] = 8'hFF;
    for (int j = 0; j < 3; j++) send(0, msg_buf[j], (j == 2), 1'b1);
    wait_digest(0, 5, model(3, 64), "t4_directed");
    for (int m = 0; m < 2; m++) begin
      n = $urandom_range(2, 6);
      for (int j = 0; j < n; j++) msg_buf[j] = 8'($urandom_range(0, 255));
      for (int j = 0; j < n; j++) send(0, msg_buf[j], (j == n - 1), 1'b1);
      wait_digest(0, 5, model(n, 64), "t4_random");
    end

    // 4-bit length counter: saturation at 15 and sticky flag.
    for (int j = 0; j < 17; j++) msg_buf[j] = 8'(j * 37 + 5);
    for (int j = 0; j < 17; j++) begin
      send(3, msg_buf[j], (j == 16), 1'b0);
      if (j == 14) check("t5_ovf_at_15", {31'd0, ovf[3]}, 32'd0);
      if (j == 15) check("t5_ovf_at_16", {31'd0, ovf[3]}, 32'd1);
    end
    wait_digest(3, 5, model(17, 4), "t5_sat");
    check("t5_ovf_held", {31'd0, ovf[3]}, 32'd1);
    send(3, 8'h00, 1'b1, 1'b0);
    check("t5_ovf_cleared", {31'd0, ovf[3]}, 32'd0);
    wait_digest(3, 5, 32'h1440590F, "t5_next");

    // Reset during ROUND of the third byte.
    send(0, 8'h11, 1'b0, 1'b0);
    send(0, 8'h22, 1'b0, 1'b0);
    send(0, 8'h33, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t6_busy_before_reset", {31'd0, bsy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, bsy[0]}, 32'd0);
    check("t6_ready", {31'd0, rdy[0]}, 32'd1);
    check("t6_digest", dig[0], 32'h0);
    check("t6_hash_ready", {31'd0, hrdy[0]}, 32'd0);
    check("t6_ovf_u3", {31'd0, ovf[3]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("t6_no_pulse", {31'd0, hrdy[0]}, 32'd0);
    end
    send(0, 8'h00, 1'b1, 1'b0);
    wait_digest(0, 5, 32'h1440590F, "t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
